// File: rtl/dummy_accelerator_mq_if.sv
// Offload bus between the core-side request source and the dummy accelerator.
// Carries the request channel (valid_i/ready_o plus operands), the result
// channel (valid_o/ready_i plus result/tag), flush_i and the status outputs.
// Signal suffixes are as seen from the accelerator.
//   slave  : the accelerator side (takes requests, produces results)
//   master : the requester / write-back side
// Handshake rule for both channels: a transfer happens on a rising clock edge
// where valid and ready are both high. Once raised, valid_o and its payload
// hold until that transfer. ready_o never depends combinationally on valid_i.
interface dummy_accelerator_mq_if #(
  parameter int  WIDTH     = 32,
  parameter int  IMM_WIDTH = 11,
  parameter int  DEPTH     = 4,
  parameter type TagType   = logic [4:0]
);
  logic                   flush_i;
  logic                   valid_i;
  logic                   ready_o;
  logic [WIDTH-1:0]       rs1_value_i;
  logic [IMM_WIDTH-1:0]   imm_i;
  logic [1:0]             mode_i;
  TagType                 tag_i;
  logic                   valid_o;
  logic                   ready_i;
  logic [WIDTH-1:0]       result_o;
  TagType                 tag_o;
  logic [$clog2(DEPTH):0] occupancy_o;
  logic                   busy_o;

  modport slave (
    input  flush_i, valid_i, rs1_value_i, imm_i, mode_i, tag_i, ready_i,
    output ready_o, valid_o, result_o, tag_o, occupancy_o, busy_o
  );

  modport master (
    output flush_i, valid_i, rs1_value_i, imm_i, mode_i, tag_i, ready_i,
    input  ready_o, valid_o, result_o, tag_o, occupancy_o, busy_o
  );
endinterface

// File: rtl/dummy_accelerator_mq.sv
// Dummy multi-outstanding accelerator.
// Requests are queued in a DEPTH-entry circular FIFO and executed in order.
// Each request waits imm[LAT_WIDTH-1:0] cycles, then presents
// rs1 op imm (XOR / ADD / SUB / ROTL selected by mode) with its tag.
// Ports:
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset
//   bus     : request/result channels, flush and status (slave modport)
//   state_o : current FSM state (IDLE=0, BUSY=1, DONE=2), for observation
module dummy_accelerator_mq #(
  parameter int  WIDTH     = 32,
  parameter int  IMM_WIDTH = 11,
  parameter int  LAT_WIDTH = 4,
  parameter int  DEPTH     = 4,
  parameter type TagType   = logic [4:0]
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  dummy_accelerator_mq_if.slave  bus,
  output logic [1:0]             state_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int SW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Queue storage; no reset needed, validity is tracked by the pointers.
  logic [WIDTH-1:0]     q_rs1  [DEPTH];
  logic [IMM_WIDTH-1:0] q_imm  [DEPTH];
  logic [1:0]           q_mode [DEPTH];
  TagType               q_tag  [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW:0] wr_ptr, rd_ptr;
  logic        empty, full, push, pop;

  logic [1:0]           state;
  logic [LAT_WIDTH-1:0] cnt;
  logic [LAT_WIDTH-1:0] exec_lat;
  logic [WIDTH-1:0]     exec_result;
  TagType               exec_tag;
  logic [WIDTH-1:0]     result_q;
  TagType               tag_q;

  logic [WIDTH-1:0]     h_rs1;
  logic [IMM_WIDTH-1:0] h_imm;
  logic [1:0]           h_mode;
  TagType               h_tag;
  logic [LAT_WIDTH-1:0] h_lat;
  logic [WIDTH-1:0]     imm_ext;
  logic [2*WIDTH-1:0]   rot;
  logic [WIDTH-1:0]     head_result;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  // Flush wins over everything; a request presented with flush is dropped.
  assign push = bus.valid_i && !full && !bus.flush_i;
  assign pop  = !bus.flush_i && !empty &&
                ((state == IDLE) || ((state == DONE) && bus.ready_i));

  assign h_rs1  = q_rs1[rd_ptr[PW-1:0]];
  assign h_imm  = q_imm[rd_ptr[PW-1:0]];
  assign h_mode = q_mode[rd_ptr[PW-1:0]];
  assign h_tag  = q_tag[rd_ptr[PW-1:0]];
  assign h_lat  = h_imm[LAT_WIDTH-1:0];

  // The result of the head entry is computed combinationally and captured
  // when that entry is popped, so no arithmetic sits behind result_o.
  always_comb begin
    imm_ext = WIDTH'(h_imm);
    // Rotate by shifting a doubled copy; the upper half is the rotated word.
    rot     = {h_rs1, h_rs1} << h_imm[SW-1:0];
    case (h_mode)
      2'd0:    head_result = h_rs1 ^ imm_ext;
      2'd1:    head_result = h_rs1 + imm_ext;
      2'd2:    head_result = h_rs1 - imm_ext;
      default: head_result = rot[2*WIDTH-1:WIDTH];
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      q_rs1[wr_ptr[PW-1:0]]  <= bus.rs1_value_i;
      q_imm[wr_ptr[PW-1:0]]  <= bus.imm_i;
      q_mode[wr_ptr[PW-1:0]] <= bus.mode_i;
      q_tag[wr_ptr[PW-1:0]]  <= bus.tag_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      state       <= IDLE;
      cnt         <= '0;
      exec_lat    <= '0;
      exec_result <= '0;
      exec_tag    <= '0;
      result_q    <= '0;
      tag_q       <= '0;
    end else if (bus.flush_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      state    <= IDLE;
      cnt      <= '0;
      result_q <= '0;
      tag_q    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      if (pop) begin
        // Covers both the IDLE load and the back-to-back load out of DONE.
        exec_result <= head_result;
        exec_tag    <= h_tag;
        exec_lat    <= h_lat;
        cnt         <= '0;
        if (h_lat == '0) begin
          state    <= DONE;
          result_q <= head_result;
          tag_q    <= h_tag;
        end else begin
          state <= BUSY;
        end
      end else begin
        case (state)
          IDLE: state <= IDLE;
          BUSY: begin
            // result_o only changes on entry to DONE so it holds its last
            // value while the next entry is waiting.
            if (cnt == exec_lat - LAT_WIDTH'(1)) begin
              state    <= DONE;
              result_q <= exec_result;
              tag_q    <= exec_tag;
            end else begin
              cnt <= cnt + LAT_WIDTH'(1);
            end
          end
          DONE: if (bus.ready_i) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.ready_o     = !full;
  assign bus.valid_o     = (state == DONE);
  assign bus.result_o    = result_q;
  assign bus.tag_o       = tag_q;
  assign bus.occupancy_o = wr_ptr - rd_ptr;
  assign bus.busy_o      = (state != IDLE) || !empty;
  assign state_o         = state;

endmodule

// File: tb/tb_dummy_accelerator_mq.sv
// Self-checking bench for dummy_accelerator_mq: directed latency/result
// vectors, full-queue backpressure, pointer wrap, flush and async reset.
module tb_dummy_accelerator_mq;
  localparam int W  = 32;
  localparam int EW = W + 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] state;
  always #5 clk = ~clk;

  dummy_accelerator_mq_if #(.WIDTH(32), .IMM_WIDTH(11), .DEPTH(4)) bus ();

  dummy_accelerator_mq #(
    .WIDTH(32), .IMM_WIDTH(11), .LAT_WIDTH(4), .DEPTH(4)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .bus     (bus.slave),
    .state_o (state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check_eq(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] rs1, input logic [10:0] imm,
                                         input logic [1:0] mode);
    int s;
    s = int'(imm[4:0]);
    case (mode)
      2'd0: model = rs1 ^ {21'd0, imm};
      2'd1: model = rs1 + {21'd0, imm};
      2'd2: model = rs1 - {21'd0, imm};
      default: model = (s == 0) ? rs1 : ((rs1 << s) | (rs1 >> (32 - s)));
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  // Inputs change 1ns after posedge, so at negedge valid/ready are settled and
  // predict the transfer on the coming edge.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst && !bus.flush_i && bus.valid_o && bus.ready_i) begin
      check_eq("out_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("out_result", bus.result_o, e[W-1:0]);
        check_eq("out_tag", bus.tag_o, e[EW-1:W]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [W-1:0] rs1, input logic [10:0] imm,
                         input logic [1:0] mode, input logic [4:0] tag);
    bus.valid_i     = 1'b1;
    bus.rs1_value_i = rs1;
    bus.imm_i       = imm;
    bus.mode_i      = mode;
    bus.tag_i       = tag;
  endtask

  // One request into an idle accelerator; measures latency from the handshake
  // cycle to the first valid_o cycle.
  task automatic run_single(input string name, input logic [W-1:0] rs1, input logic [10:0] imm,
                            input logic [1:0] mode, input logic [4:0] tag,
                            input int exp_lat, input logic [W-1:0] exp_res);
    int n;
    bus.ready_i = 1'b1;
    set_req(rs1, imm, mode, tag);
    check_eq({name, "_ready"}, bus.ready_o, 1);
    exp_q.push_back({tag, exp_res});
    step();
    bus.valid_i = 1'b0;
    n = 1;
    while (!bus.valid_o && n < 40) begin
      step();
      n++;
    end
    check_eq({name, "_latency"}, n, exp_lat);
    check_eq({name, "_result"}, bus.result_o, exp_res);
    check_eq({name, "_tag"}, bus.tag_o, tag);
    step();
    check_eq({name, "_valid_drop"}, bus.valid_o, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int idx, sent, cnt;
    logic [W-1:0] hold_res;
    logic [4:0]   hold_tag;
    logic [W-1:0] r;
    logic [10:0]  im;
    logic [1:0]   md;

    bus.flush_i = 0; bus.valid_i = 0; bus.rs1_value_i = 0; bus.imm_i = 0;
    bus.mode_i = 0; bus.tag_i = 0; bus.ready_i = 0;
    #1;
    check_eq("rst_valid", bus.valid_o, 0);
    check_eq("rst_result", bus.result_o, 0);
    check_eq("rst_tag", bus.tag_o, 0);
    check_eq("rst_occ", bus.occupancy_o, 0);
    check_eq("rst_busy", bus.busy_o, 0);
    check_eq("rst_ready", bus.ready_o, 1);
    step(); step();
    rst = 1'b0;
    step();

    // Directed single requests.
    run_single("xor", 32'h0000_00F0, 11'h005, 2'd0, 5'd3, 7, 32'h0000_00F5);
    run_single("add", 32'hFFFF_FFFF, 11'h001, 2'd1, 5'd4, 3, 32'h0000_0000);
    run_single("sub", 32'h0000_0000, 11'h010, 2'd2, 5'd5, 2, 32'hFFFF_FFF0);
    run_single("rotl", 32'h8000_0001, 11'h004, 2'd3, 5'd6, 6, 32'h0000_0018);

    // Full queue under backpressure: 1 executing + 4 queued.
    bus.ready_i = 1'b0;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      set_req(32'h100 + idx, 11'h000, 2'd0, 5'(10 + idx));
      if (bus.ready_o) begin
        exp_q.push_back({5'(10 + idx), 32'h100 + idx});
        idx++;
      end
      step();
    end
    bus.valid_i = 1'b0;
    check_eq("full_accepted", idx, 5);
    check_eq("full_ready", bus.ready_o, 0);
    check_eq("full_occ", bus.occupancy_o, 4);
    check_eq("full_valid", bus.valid_o, 1);
    check_eq("full_head_tag", bus.tag_o, 10);
    check_eq("full_head_res", bus.result_o, 32'h100);
    hold_res = bus.result_o;
    hold_tag = bus.tag_o;
    step(); step(); step();
    check_eq("stall_res_stable", bus.result_o, hold_res);
    check_eq("stall_tag_stable", bus.tag_o, hold_tag);
    bus.ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i < 4) check_eq("drain_b2b_valid", bus.valid_o, 1);
    end
    check_eq("drain_busy", bus.busy_o, 0);
    check_eq("drain_valid", bus.valid_o, 0);
    check_eq("drain_empty", exp_q.size(), 0);

    // Wrap-around with random modes and toggling ready_i.
    sent = 0;
    cnt = 0;
    while ((sent < 12 || exp_q.size() != 0) && cnt < 600) begin
      bus.ready_i = 1'($urandom_range(0, 1));
      if (sent < 12) begin
        r  = $urandom;
        im = 11'($urandom_range(0, 2047)) & 11'h7F3;
        md = 2'($urandom_range(0, 3));
        set_req(r, im, md, 5'(sent));
        if (bus.ready_o) begin
          exp_q.push_back({5'(sent), model(r, im, md)});
          sent++;
        end
      end else begin
        bus.valid_i = 1'b0;
      end
      step();
      cnt++;
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    check_eq("wrap_sent", sent, 12);
    check_eq("wrap_drained", exp_q.size(), 0);
    step(); step();

    // Flush while BUSY with three queued entries.
    set_req(32'h1, 11'h00A, 2'd0, 5'd20);
    step();
    for (int i = 0; i < 3; i++) begin
      set_req(32'h2 + i, 11'h000, 2'd1, 5'(21 + i));
      step();
    end
    bus.valid_i = 1'b0;
    check_eq("preflush_occ", bus.occupancy_o, 3);
    check_eq("preflush_state", state, 1);
    bus.flush_i = 1'b1;
    set_req(32'h9, 11'h000, 2'd0, 5'd24);
    step();
    bus.flush_i = 1'b0;
    bus.valid_i = 1'b0;
    check_eq("flush_valid", bus.valid_o, 0);
    check_eq("flush_occ", bus.occupancy_o, 0);
    check_eq("flush_busy", bus.busy_o, 0);
    check_eq("flush_result", bus.result_o, 0);
    check_eq("flush_tag", bus.tag_o, 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.valid_o) cnt++;
      step();
    end
    check_eq("flush_no_output", cnt, 0);
    check_eq("flush_drop_req", bus.occupancy_o, 0);

    // Async reset mid-BUSY.
    run_single("pre_rst", 32'h0000_0050, 11'h005, 2'd0, 5'd7, 7, 32'h0000_0055);
    set_req(32'h3, 11'h008, 2'd0, 5'd8);
    step();
    set_req(32'h4, 11'h000, 2'd0, 5'd9);
    step();
    set_req(32'h5, 11'h000, 2'd0, 5'd10);
    step();
    bus.valid_i = 1'b0;
    check_eq("prerst_occ", bus.occupancy_o, 2);
    check_eq("prerst_state", state, 1);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    check_eq("arst_valid", bus.valid_o, 0);
    check_eq("arst_result", bus.result_o, 0);
    check_eq("arst_tag", bus.tag_o, 0);
    check_eq("arst_occ", bus.occupancy_o, 0);
    check_eq("arst_busy", bus.busy_o, 0);
    check_eq("arst_ready", bus.ready_o, 1);
    step();
    #2 rst = 1'b0;
    step();
    run_single("post_rst", 32'h0000_1234, 11'h003, 2'd0, 5'd9, 5, 32'h0000_1237);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
